// File: rtl/demux_tdm_pkg.sv
// Shared types and default sizes for the two-slot TDM demultiplexer.
// The state encoding is fixed because the debug tap exposes it directly.
package demux_tdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXP0 = 2'd1,
        ST_EXP1 = 2'd2
    } demux_state_e;

    localparam int unsigned DEMUX_W_DEF     = 1;
    localparam int unsigned DEMUX_CNT_W_DEF = 8;

endpackage

// File: rtl/demux_slot_reg.sv
// Held W-bit slot register with load enable, sync active-low clear,
// and a one-cycle strobe that marks the cycle the new value appears.
module demux_slot_reg
    import demux_tdm_pkg::*;
#(
    parameter int unsigned W = DEMUX_W_DEF
) (
    input  logic         clk,
    input  logic         clr_n_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         stb_o
);

    logic [W-1:0] data_q;
    logic         stb_q;

    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            data_q <= '0;
            stb_q  <= 1'b0;
        end else begin
            stb_q <= load_i;
            if (load_i) begin
                data_q <= d_i;
            end
        end
    end

    assign q_o   = data_q;
    assign stb_o = stb_q;

endmodule

// File: rtl/demux_tdm_w2.sv
// Two-slot TDM receive demux: splits a sync-flagged beat stream onto two held
// outputs. Optional debug tap (dbg_state, dbg_drop) under DEMUX_TDM_DEBUG_TAP_EN.
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | unlocked, waiting for a sync beat
// EXP0    | locked, next beat must be slot 0 (sync=1)
// EXP1    | slot 0 held, next beat should be slot 1
module demux_tdm_w2
    import demux_tdm_pkg::*;
#(
    parameter int unsigned W     = DEMUX_W_DEF,
    parameter int unsigned CNT_W = DEMUX_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic [W-1:0]     in_data,
    output logic [W-1:0]     out0,
    output logic [W-1:0]     out1,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             pair_valid,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt
`ifdef DEMUX_TDM_DEBUG_TAP_EN
    ,
    output logic [1:0]       dbg_state,
    output logic             dbg_drop
`endif
);

    demux_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             pair_q;
    logic             load0_d, load1_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        load0_d = 1'b0;
        load1_d = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_sync) begin
                        load0_d = 1'b1;
                        state_d = ST_EXP1;
                    end
                end
                ST_EXP0: begin
                    if (in_sync) begin
                        load0_d = 1'b1;
                        state_d = ST_EXP1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EXP1: begin
                    if (in_sync) begin
                        // premature resync: the beat restarts the frame as slot 0
                        err_d   = 1'b1;
                        load0_d = 1'b1;
                    end else begin
                        load1_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_EXP0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            pair_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pair_q  <= load1_d;
        end
    end

    demux_slot_reg #(.W(W)) u_slot0 (
        .clk     (clk),
        .clr_n_i (rst_n),
        .load_i  (load0_d),
        .d_i     (in_data),
        .q_o     (out0),
        .stb_o   (out0_valid)
    );

    demux_slot_reg #(.W(W)) u_slot1 (
        .clk     (clk),
        .clr_n_i (rst_n),
        .load_i  (load1_d),
        .d_i     (in_data),
        .q_o     (out1),
        .stb_o   (out1_valid)
    );

    assign pair_valid = pair_q;
    assign sync_err   = err_q;
    assign frame_cnt  = cnt_q;

`ifdef DEMUX_TDM_DEBUG_TAP_EN
    logic drop_q;

    // every non-sync beat outside EXP1 is discarded, silent or not
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= in_valid && !in_sync && (state_q != ST_EXP1);
        end
    end

    assign dbg_state = state_q;
    assign dbg_drop  = drop_q;
`endif

endmodule

// File: tb/tb_demux_tdm_w2.sv
// Randomized plus directed bench for demux_tdm_w2 (W=4, CNT_W=2) against a
// frame-level reference model; covers the debug tap when DEMUX_TDM_DEBUG_TAP_EN is set.
module tb_demux_tdm_w2;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_sync;
    logic [W-1:0]     in_data;
    logic [W-1:0]     out0, out1;
    logic             out0_valid, out1_valid, pair_valid, sync_err;
    logic [CNT_W-1:0] frame_cnt;
`ifdef DEMUX_TDM_DEBUG_TAP_EN
    logic [1:0]       dbg_state;
    logic             dbg_drop;
`endif

    demux_tdm_w2 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .in_data    (in_data),
        .out0       (out0),
        .out1       (out1),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .pair_valid (pair_valid),
        .sync_err   (sync_err),
        .frame_cnt  (frame_cnt)
`ifdef DEMUX_TDM_DEBUG_TAP_EN
        ,
        .dbg_state  (dbg_state),
        .dbg_drop   (dbg_drop)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: frame-level view (are we locked, is half a frame held)
    bit locked, half;
    int m_out0, m_out1, m_cnt;
    bit m_o0v, m_o1v, m_pv, m_err, m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model(input bit r, input bit v, input bit s, input int d);
        m_o0v = 0; m_o1v = 0; m_pv = 0; m_err = 0; m_drop = 0;
        if (!r) begin
            locked = 0; half = 0;
            m_out0 = 0; m_out1 = 0; m_cnt = 0;
        end else if (v) begin
            if (s) begin
                if (half) m_err = 1;
                m_out0 = d; m_o0v = 1;
                half = 1; locked = 1;
            end else if (half) begin
                m_out1 = d; m_o1v = 1; m_pv = 1;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                half = 0;
            end else begin
                m_drop = 1;
                if (locked) begin
                    m_err = 1;
                    locked = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input int d);
        rst_n    = r;
        in_valid = v;
        in_sync  = s;
        in_data  = W'(d);
        @(posedge clk);
        #1;
        model(r, v, s, d);
        chk("out0",       32'(out0),       32'(m_out0));
        chk("out1",       32'(out1),       32'(m_out1));
        chk("out0_valid", 32'(out0_valid), 32'(m_o0v));
        chk("out1_valid", 32'(out1_valid), 32'(m_o1v));
        chk("pair_valid", 32'(pair_valid), 32'(m_pv));
        chk("sync_err",   32'(sync_err),   32'(m_err));
        chk("frame_cnt",  32'(frame_cnt),  32'(m_cnt));
`ifdef DEMUX_TDM_DEBUG_TAP_EN
        chk("dbg_state", 32'(dbg_state), !locked ? 32'd0 : (half ? 32'd2 : 32'd1));
        chk("dbg_drop",  32'(dbg_drop),  32'(m_drop));
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
        locked = 0; half = 0; m_out0 = 0; m_out1 = 0; m_cnt = 0;

        // reset state
        step(0, 0, 0, 0);
        step(0, 1, 1, 9);

        // basic frame
        step(1, 1, 1, 'hA);
        step(1, 1, 0, 'h5);
        step(1, 0, 0, 'h0);

        // unlock, then silent drops in IDLE, then relock
        step(1, 1, 0, 'h1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, i + 2);
        step(1, 1, 1, 'h3);
        step(1, 1, 0, 'h2);

        // locked and expecting slot 0, non-sync beat
        step(1, 1, 0, 'h7);
        step(1, 0, 1, 'hF);

        // premature resync in EXP1, then completion
        step(1, 1, 1, 'h4);
        step(1, 1, 1, 'hC);
        step(1, 1, 0, 'h6);

        // five frames to exercise counter wrap
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, i);
            step(1, 1, 0, 15 - i);
        end

        // reset in EXP1 alongside a valid beat, then a non-sync beat is dropped
        step(1, 1, 1, 'hB);
        step(0, 1, 0, 'h9);
        step(1, 1, 0, 'h4);
        step(1, 0, 0, 'h0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 4,
                 int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
